// File: rtl/stb_gen_avg.sv
// stb_gen_avg
//
// Strobe generator for the measure unit. After a start pulse it discards
// SKIP_EDGES rising edges of sig_i. It then averages the next 2**AVG_LOG2
// periods of sig_i, measured in clk_i cycles. From then on it free-runs a
// strobe with that averaged period P.
//
// The strobe period starts at a programmable phase offset. Each period ends
// with a runtime-selectable number of low cycles. A sticky error flag
// reports a period counter overflow.
//
// Ports:
//   clk_i          system clock, single clock domain
//   rst_i          synchronous reset, active-high, beats every other input
//   sig_i          asynchronous measured signal
//   start_i        one-cycle pulse that (re)starts a measurement
//   oe_i           strobe output enable, sampled every cycle
//   err_clr_i      clears err_o
//   hold_cycles_i  low cycles at the end of every strobe period
//   phase_i        p_cnt preload, sampled only when RUN is entered
//   rdy_o          high while not measuring (IDLE or RUN)
//   err_o          sticky period counter overflow flag
//   period_vld_o   one-cycle pulse when stb_period_o takes a new value
//   stb_period_o   averaged period P in clk_i cycles
//   stb_o          registered strobe output

module stb_gen_avg #(
    parameter int T_CNT_WIDTH = 32,
    parameter int AVG_LOG2    = 2,
    parameter int SKIP_EDGES  = 1,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_WIDTH  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sig_i,
    input  logic                   start_i,
    input  logic                   oe_i,
    input  logic                   err_clr_i,
    input  logic [HOLD_WIDTH-1:0]  hold_cycles_i,
    input  logic [T_CNT_WIDTH-1:0] phase_i,
    output logic                   rdy_o,
    output logic                   err_o,
    output logic                   period_vld_o,
    output logic [T_CNT_WIDTH-1:0] stb_period_o,
    output logic                   stb_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    localparam int ACC_W  = T_CNT_WIDTH + AVG_LOG2;
    localparam int AVG_N  = 1 << AVG_LOG2;
    localparam int EC_MAX = (SKIP_EDGES > AVG_N) ? SKIP_EDGES : AVG_N;
    localparam int EC_W   = $clog2(EC_MAX + 1);

    localparam logic [EC_W-1:0] SKIP_LAST = EC_W'(SKIP_EDGES - 1);
    localparam logic [EC_W-1:0] AVG_LAST  = EC_W'(AVG_N - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   edge_q;

    logic [1:0]             state_q;
    logic [T_CNT_WIDTH-1:0] t_cnt_q;
    logic [T_CNT_WIDTH-1:0] p_cnt_q;
    logic [ACC_W-1:0]       acc_q;
    logic [EC_W-1:0]        edge_cnt_q;

    logic [ACC_W-1:0]       acc_next;
    logic [T_CNT_WIDTH-1:0] p_new;
    logic                   t_ovf;
    logic                   stb_on;

    // Synchroniser chain followed by a registered rising-edge detect.
    // An edge event appears SYNC_STAGES+1 cycles after sig_i rises.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            edge_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], sig_i};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            edge_q      <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
        end
    end

    // The accumulator includes the period that closes on this edge.
    // That way the final average can be taken in the same cycle.
    // The strobe compare is written as p_cnt + hold < P.
    // It is evaluated one bit wider, so hold > P simply gives "off"
    // instead of wrapping around.
    always_comb begin
        acc_next = acc_q + ACC_W'(t_cnt_q) + ACC_W'(1);
        p_new    = acc_next[ACC_W-1:AVG_LOG2];
        t_ovf    = (&t_cnt_q) & ~edge_q;
        stb_on   = (({1'b0, p_cnt_q} + (T_CNT_WIDTH+1)'(hold_cycles_i))
                    < {1'b0, stb_period_o});
    end

    // Main control FSM.
    // start_i wins over any edge or overflow in the same cycle.
    // An overflow set wins over a same-cycle err_clr_i, because the
    // later non-blocking assignment takes effect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            t_cnt_q      <= '0;
            p_cnt_q      <= '0;
            acc_q        <= '0;
            edge_cnt_q   <= '0;
            stb_period_o <= '0;
            period_vld_o <= 1'b0;
            rdy_o        <= 1'b1;
            err_o        <= 1'b0;
            stb_o        <= 1'b0;
        end else begin
            period_vld_o <= 1'b0;
            if (err_clr_i) begin
                err_o <= 1'b0;
            end
            if (start_i) begin
                state_q    <= ST_SKIP;
                t_cnt_q    <= '0;
                acc_q      <= '0;
                edge_cnt_q <= '0;
                err_o      <= 1'b0;
                rdy_o      <= 1'b0;
                stb_o      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        stb_o <= 1'b0;
                    end
                    ST_SKIP: begin
                        stb_o <= 1'b0;
                        if (t_ovf) begin
                            err_o   <= 1'b1;
                            rdy_o   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (edge_q && edge_cnt_q == SKIP_LAST) begin
                            t_cnt_q    <= '0;
                            edge_cnt_q <= '0;
                            state_q    <= ST_MEAS;
                        end else begin
                            if (edge_q) begin
                                edge_cnt_q <= edge_cnt_q + EC_W'(1);
                            end
                            t_cnt_q <= t_cnt_q + T_CNT_WIDTH'(1);
                        end
                    end
                    ST_MEAS: begin
                        stb_o <= 1'b0;
                        if (t_ovf) begin
                            err_o   <= 1'b1;
                            rdy_o   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (edge_q) begin
                            acc_q      <= acc_next;
                            t_cnt_q    <= '0;
                            edge_cnt_q <= edge_cnt_q + EC_W'(1);
                            if (edge_cnt_q == AVG_LAST) begin
                                stb_period_o <= p_new;
                                period_vld_o <= 1'b1;
                                p_cnt_q      <= (phase_i < p_new) ? phase_i : '0;
                                rdy_o        <= 1'b1;
                                state_q      <= ST_RUN;
                            end
                        end else begin
                            t_cnt_q <= t_cnt_q + T_CNT_WIDTH'(1);
                        end
                    end
                    ST_RUN: begin
                        if (p_cnt_q == stb_period_o - T_CNT_WIDTH'(1)) begin
                            p_cnt_q <= '0;
                        end else begin
                            p_cnt_q <= p_cnt_q + T_CNT_WIDTH'(1);
                        end
                        stb_o <= oe_i & ~err_o & stb_on;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        stb_o   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stb_gen_avg.sv
// tb_stb_gen_avg
//
// Bench for stb_gen_avg, built with an 8-bit period counter so that the
// overflow path can be reached quickly. The reference model works at the
// transaction level:
//   - The expected period is the truncated mean of the four edge gaps
//     the bench drives.
//   - The expected strobe is derived from the position within the period:
//     (phase + cycles since RUN entry) mod P, compared against P - hold.
//
// Ports: drives every input of stb_gen_avg and observes every output.

module tb_stb_gen_avg;

    localparam int TW   = 8;
    localparam int AVG  = 2;
    localparam int SKIP = 1;
    localparam int SYNC = 2;
    localparam int HW   = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          sig_i;
    logic          start_i;
    logic          oe_i;
    logic          err_clr_i;
    logic [HW-1:0] hold_cycles_i;
    logic [TW-1:0] phase_i;
    logic          rdy_o;
    logic          err_o;
    logic          period_vld_o;
    logic [TW-1:0] stb_period_o;
    logic          stb_o;

    int checkCount = 0;
    int errorCount = 0;
    int lastP      = 0;
    int curP       = 1;
    int runPos     = 0;

    stb_gen_avg #(
        .T_CNT_WIDTH (TW),
        .AVG_LOG2    (AVG),
        .SKIP_EDGES  (SKIP),
        .SYNC_STAGES (SYNC),
        .HOLD_WIDTH  (HW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sig_i         (sig_i),
        .start_i       (start_i),
        .oe_i          (oe_i),
        .err_clr_i     (err_clr_i),
        .hold_cycles_i (hold_cycles_i),
        .phase_i       (phase_i),
        .rdy_o         (rdy_o),
        .err_o         (err_o),
        .period_vld_o  (period_vld_o),
        .stb_period_o  (stb_period_o),
        .stb_o         (stb_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Hard time limit, so that a broken design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d",
                 checkCount, errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge, then move away from it before sampling.
    task automatic stepClock();
        @(posedge clk_i);
        #1;
    endtask

    // Drive the control inputs for the next clock edge.
    task automatic applyStimulus(input logic start, input logic oe,
                                 input logic clr, input int hold);
        start_i       = start;
        oe_i          = oe;
        err_clr_i     = clr;
        hold_cycles_i = HW'(hold);
    endtask

    // Produce one skipped edge at preGap, then four measured gaps.
    // Outputs are checked every cycle until the result is expected.
    task automatic measurePeriod(input int gaps[4], input int preGap,
                                 input bit useStart, input int phase);
        int   rise[5];
        int   sum;
        int   expP;
        int   last;
        logic s;
        sum     = 0;
        rise[0] = preGap;
        for (int i = 1; i < 5; i++) begin
            rise[i] = rise[i-1] + gaps[i-1];
            sum     += gaps[i-1];
        end
        expP    = sum / 4;
        phase_i = TW'(phase);
        if (useStart) begin
            start_i = 1'b1;
            stepClock();
            start_i = 1'b0;
            checkOutput("start_rdy", rdy_o, 0);
            checkOutput("start_stb", stb_o, 0);
        end
        last = rise[4] + SYNC + 1;
        for (int t = 0; t <= last; t++) begin
            s = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (t == rise[k]) s = 1'b1;
            end
            sig_i = s;
            stepClock();
            checkOutput("meas_vld", period_vld_o, (t == last) ? 1 : 0);
            checkOutput("meas_rdy", rdy_o, (t == last) ? 1 : 0);
            checkOutput("meas_stb", stb_o, 0);
            checkOutput("meas_period", stb_period_o, (t == last) ? expP : lastP);
        end
        sig_i  = 1'b0;
        lastP  = expP;
        curP   = expP;
        runPos = (phase < expP) ? phase : 0;
    endtask

    // Run the strobe, with either fixed or randomly changing oe and hold.
    task automatic runStrobe(input int cycles, input bit randomMode,
                             input int hold, input bit oe);
        int h;
        bit o;
        bit exp;
        h = hold;
        o = oe;
        for (int k = 0; k < cycles; k++) begin
            if (randomMode) begin
                o = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) h = $urandom_range(0, curP + 2);
            end
            exp = o && (runPos < curP - h);
            applyStimulus(1'b0, o, 1'b0, h);
            stepClock();
            checkOutput("run_stb", stb_o, exp);
            checkOutput("run_vld", period_vld_o, 0);
            runPos = (runPos + 1) % curP;
        end
    endtask

    // Drive start, then let the period counter run to overflow.
    // Edges are never produced. clrAtOvf asserts err_clr_i in the
    // overflow cycle itself.
    task automatic runOverflow(input bit clrAtOvf);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 256; k++) begin
            if (k == 256) err_clr_i = clrAtOvf;
            stepClock();
            if (k == 255) begin
                checkOutput("ovf_err_early", err_o, 0);
                checkOutput("ovf_rdy_early", rdy_o, 0);
            end
        end
        err_clr_i = 1'b0;
        checkOutput("ovf_err", err_o, 1);
        checkOutput("ovf_rdy", rdy_o, 1);
        checkOutput("ovf_stb", stb_o, 0);
        checkOutput("ovf_period", stb_period_o, lastP);
        for (int k = 0; k < 5; k++) stepClock();
        checkOutput("ovf_sticky", err_o, 1);
        checkOutput("ovf_idle_stb", stb_o, 0);
        err_clr_i = 1'b1;
        stepClock();
        err_clr_i = 1'b0;
        checkOutput("ovf_clr", err_o, 0);
    endtask

    // Build four random edge gaps, measure them, then run the strobe
    // with random oe and hold.
    task automatic randomRound(input int runCycles);
        int g[4];
        for (int i = 0; i < 4; i++) g[i] = $urandom_range(3, 60);
        measurePeriod(g, $urandom_range(1, 8), 1'b1, $urandom_range(0, 63));
        runStrobe(runCycles, 1'b1, $urandom_range(0, 8), 1'b1);
    endtask

    initial begin
        rst_i = 1'b1;
        sig_i = 1'b0;
        phase_i = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) stepClock();
        rst_i = 1'b0;
        checkOutput("rst_rdy", rdy_o, 1);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_vld", period_vld_o, 0);
        checkOutput("rst_period", stb_period_o, 0);
        checkOutput("rst_stb", stb_o, 0);
        stepClock();
        checkOutput("idle_stb", stb_o, 0);

        // Constant period 10. The strobe is 7 high / 3 low, then oe drops.
        measurePeriod('{10, 10, 10, 10}, 3, 1'b1, 0);
        runStrobe(30, 1'b0, 3, 1'b1);
        runStrobe(1, 1'b0, 3, 1'b0);
        runStrobe(5, 1'b0, 3, 1'b1);

        // Mixed periods truncate to 10. Large, equal and zero hold values.
        measurePeriod('{10, 11, 10, 12}, 3, 1'b1, 4);
        runStrobe(20, 1'b0, 12, 1'b1);
        runStrobe(12, 1'b0, 10, 1'b1);
        runStrobe(12, 1'b0, 0, 1'b1);

        // Abort mid-measurement. The restart coincides with an edge event,
        // so that edge must not be taken as the skip edge.
        measurePeriod('{14, 14, 14, 14}, 2, 1'b1, 20);
        runStrobe(15, 1'b1, 2, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        stepClock();
        start_i = 1'b0;
        for (int t = 0; t <= 35; t++) begin
            sig_i   = (t == 2 || t == 12 || t == 22 || t == 32);
            start_i = (t == 35);
            stepClock();
            checkOutput("abort_vld", period_vld_o, 0);
            checkOutput("abort_rdy", rdy_o, 0);
            checkOutput("abort_period", stb_period_o, lastP);
        end
        start_i = 1'b0;
        sig_i   = 1'b0;
        measurePeriod('{10, 10, 10, 10}, 26, 1'b0, 3);
        runStrobe(20, 1'b1, 1, 1'b1);

        // Overflow with no edges, a plain clear, then a clear that
        // collides with the overflow.
        runOverflow(1'b0);
        runOverflow(1'b1);

        // Reset while the strobe is running.
        randomRound(30);
        rst_i = 1'b1;
        stepClock();
        rst_i = 1'b0;
        lastP = 0;
        checkOutput("runrst_stb", stb_o, 0);
        checkOutput("runrst_rdy", rdy_o, 1);
        checkOutput("runrst_err", err_o, 0);
        checkOutput("runrst_period", stb_period_o, 0);
        checkOutput("runrst_vld", period_vld_o, 0);
        stepClock();
        checkOutput("runrst_idle_stb", stb_o, 0);

        for (int r = 0; r < 4; r++) randomRound(80);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
